// File: rtl/uart_rx_oversampled.sv
// UART receiver driven by a 16x oversample strobe: samples start, data and stop bits
// at their midpoints and reports each completed frame with a one-clk done pulse.
module uart_rx_oversampled #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic            rx,
   output logic [DBIT-1:0] dout,
   output logic            rx_done_tick,
   output logic            frame_err,
   output logic            rx_busy
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [4:0] START_MID   = 5'd7;
   localparam logic [4:0] BIT_LAST    = 5'd15;
   localparam logic [4:0] STOP_SAMPLE = 5'd15;
   localparam logic [4:0] STOP_LAST   = 5'(SB_TICK - 1);
   localparam logic [2:0] N_LAST      = 3'(DBIT - 1);

   state_t          state;
   logic            rx_meta;
   logic            rx_s;
   logic [4:0]      s_cnt;
   logic [2:0]      n_cnt;
   logic [DBIT-1:0] b;
   logic            stop_sample;

   // Synchronizer flops reset high so a released reset looks like an idle line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         s_cnt        <= '0;
         n_cnt        <= '0;
         b            <= '0;
         stop_sample  <= 1'b1;
         dout         <= '0;
         frame_err    <= 1'b0;
         rx_done_tick <= 1'b0;
      end else begin
         rx_done_tick <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  s_cnt <= '0;
               end
            end
            START: begin
               if (s_tick) begin
                  if (s_cnt == START_MID) begin
                     // A line back high at mid start bit is a glitch, not a frame.
                     if (!rx_s) begin
                        state <= DATA;
                        s_cnt <= '0;
                        n_cnt <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     s_cnt <= s_cnt + 5'd1;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s_cnt == BIT_LAST) begin
                     s_cnt <= '0;
                     b     <= {rx_s, b[DBIT-1:1]};
                     if (n_cnt == N_LAST) begin
                        state <= STOP;
                     end else begin
                        n_cnt <= n_cnt + 3'd1;
                     end
                  end else begin
                     s_cnt <= s_cnt + 5'd1;
                  end
               end
            end
            STOP: begin
               if (s_tick) begin
                  if (s_cnt == STOP_SAMPLE) begin
                     stop_sample <= rx_s;
                  end
                  if (s_cnt == STOP_LAST) begin
                     // With one stop bit the sample and the exit share a tick.
                     state        <= IDLE;
                     s_cnt        <= '0;
                     dout         <= b;
                     frame_err    <= ~((s_cnt == STOP_SAMPLE) ? rx_s : stop_sample);
                     rx_done_tick <= 1'b1;
                  end else begin
                     s_cnt <= s_cnt + 5'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: frames are serialised at 16 s_ticks per
// bit, expected words queued at send time and matched on each rx_done_tick.
module tb_uart_rx_oversampled;

   localparam int TICK_DIV = 5;
   localparam int BIT_CLK  = 16 * TICK_DIV;

   typedef struct {
      logic [7:0] data;
      logic       ferr;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       s_tick = 1'b0;
   logic       rx_line = 1'b1;
   logic       sel2 = 1'b0;
   logic       rx2;
   logic [7:0] dout, dout2;
   logic       rx_done_tick, rx_done_tick2;
   logic       frame_err, frame_err2;
   logic       rx_busy, rx_busy2;

   int   checks = 0;
   int   passed = 0;
   int   cyc = 0;
   int   div = 0;
   int   done_count = 0;
   int   done2_count = 0;
   int   done_cyc1 = 0;
   int   done_cyc2 = 0;
   logic prev_done = 1'b0;
   exp_t exp_q[$];

   assign rx2 = sel2 ? rx_line : 1'b1;

   uart_rx_oversampled #(.DBIT(8), .SB_TICK(16)) dut (
      .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx_line),
      .dout(dout), .rx_done_tick(rx_done_tick), .frame_err(frame_err), .rx_busy(rx_busy)
   );

   uart_rx_oversampled #(.DBIT(8), .SB_TICK(32)) dut32 (
      .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx2),
      .dout(dout2), .rx_done_tick(rx_done_tick2), .frame_err(frame_err2), .rx_busy(rx_busy2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (div == TICK_DIV - 1) begin
         div = 0;
         s_tick = 1'b1;
      end else begin
         div++;
         s_tick = 1'b0;
      end
   end

   // Scoreboard: every done pulse must match the oldest queued frame.
   always @(negedge clk) begin
      exp_t e;
      if (rx_done_tick) begin
         done_count++;
         done_cyc1 = cyc;
         checks++;
         if (prev_done !== 1'b0) $display("FAIL done_width: rx_done_tick high 2 clks, required 1");
         else passed++;
         checks++;
         if (rx_busy !== 1'b0) $display("FAIL busy_at_done: rx_busy=%b required 0", rx_busy);
         else passed++;
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_done: dout=%h frame_err=%b with nothing expected", dout, frame_err);
         end else begin
            e = exp_q.pop_front();
            if (dout !== e.data || frame_err !== e.ferr)
               $display("FAIL frame: dout=%h frame_err=%b required dout=%h frame_err=%b",
                        dout, frame_err, e.data, e.ferr);
            else begin
               passed++;
               $display("rx frame: dout=%h frame_err=%b at cycle %0d", dout, frame_err, cyc);
            end
         end
      end
      prev_done = rx_done_tick;
      if (rx_done_tick2) begin
         done2_count++;
         done_cyc2 = cyc;
      end
   end

   task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int stop_len);
      rx_line = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_line = data[i];
         repeat (BIT_CLK) @(negedge clk);
      end
      rx_line = stop_bit;
      repeat (stop_len) @(negedge clk);
      rx_line = 1'b1;
   endtask

   task automatic wait_done(input int target, input string name);
      for (int i = 0; i < 4000 && done_count < target; i++) @(negedge clk);
      #1;
      checks++;
      if (done_count !== target)
         $display("FAIL %s: done count=%0d required %0d", name, done_count, target);
      else passed++;
   endtask

   task automatic idle(input int n);
      rx_line = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Line held low through reset release must be taken as a start bit (frame 0x00).
   task automatic test_reset;
      rx_line = 1'b0;
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (dout !== 8'h00 || frame_err !== 1'b0 || rx_done_tick !== 1'b0 || rx_busy !== 1'b0)
         $display("FAIL reset_state: dout=%h ferr=%b done=%b busy=%b required all 0",
                  dout, frame_err, rx_done_tick, rx_busy);
      else passed++;
      @(negedge clk);
      reset = 1'b0;
      exp_q.push_back('{8'h00, 1'b0});
      repeat (8) @(negedge clk);
      checks++;
      if (rx_busy !== 1'b1) $display("FAIL low_through_reset: rx_busy=%b required 1", rx_busy);
      else passed++;
      repeat (9 * BIT_CLK - 8) @(negedge clk);
      rx_line = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
      wait_done(1, "reset_low_frame");
      idle(100);
   endtask

   task automatic test_basic;
      exp_q.push_back('{8'hA5, 1'b0});
      send_frame(8'hA5, 1'b1, BIT_CLK);
      wait_done(2, "basic_a5");
      idle(100);
      checks++;
      if (rx_busy !== 1'b0) $display("FAIL basic_idle: rx_busy=%b required 0", rx_busy);
      else passed++;
   endtask

   task automatic test_glitch;
      rx_line = 1'b0;
      repeat (4 * TICK_DIV) @(negedge clk);
      checks++;
      if (rx_busy !== 1'b1) $display("FAIL glitch_start: rx_busy=%b required 1", rx_busy);
      else passed++;
      idle(300);
      checks++;
      if (done_count !== 2 || rx_busy !== 1'b0 || dout !== 8'hA5)
         $display("FAIL glitch_reject: done=%0d busy=%b dout=%h required 2 0 a5",
                  done_count, rx_busy, dout);
      else passed++;
   endtask

   // Stop bit held low only past its midpoint so the tail is not seen as a new start.
   task automatic test_frame_error;
      exp_q.push_back('{8'h3C, 1'b1});
      send_frame(8'h3C, 1'b0, 3 * BIT_CLK / 4);
      wait_done(3, "ferr_3c");
      idle(300);
      checks++;
      if (frame_err !== 1'b1 || dout !== 8'h3C)
         $display("FAIL ferr_hold: frame_err=%b dout=%h required 1 3c", frame_err, dout);
      else passed++;
      exp_q.push_back('{8'h01, 1'b0});
      send_frame(8'h01, 1'b1, BIT_CLK);
      wait_done(4, "ferr_clear_01");
      idle(100);
   endtask

   task automatic test_reset_mid_frame;
      rx_line = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      rx_line = 1'b1;
      repeat (4 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
      checks++;
      if (rx_busy !== 1'b1) $display("FAIL mid_frame_busy: rx_busy=%b required 1", rx_busy);
      else passed++;
      reset = 1'b1;
      #1;
      checks++;
      if (dout !== 8'h00 || frame_err !== 1'b0 || rx_done_tick !== 1'b0 || rx_busy !== 1'b0)
         $display("FAIL async_reset: dout=%h ferr=%b done=%b busy=%b required all 0",
                  dout, frame_err, rx_done_tick, rx_busy);
      else passed++;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      idle(10 * BIT_CLK);
      checks++;
      if (done_count !== 4) $display("FAIL partial_discard: done=%0d required 4", done_count);
      else passed++;
      exp_q.push_back('{8'h5A, 1'b0});
      send_frame(8'h5A, 1'b1, BIT_CLK);
      wait_done(5, "after_reset_5a");
      idle(100);
   endtask

   task automatic test_back_to_back;
      exp_q.push_back('{8'h00, 1'b0});
      exp_q.push_back('{8'hFF, 1'b0});
      send_frame(8'h00, 1'b1, BIT_CLK);
      send_frame(8'hFF, 1'b1, BIT_CLK);
      wait_done(7, "back_to_back");
      idle(100);
   endtask

   task automatic test_sb32;
      int n;
      sel2 = 1'b1;
      exp_q.push_back('{8'h81, 1'b0});
      send_frame(8'h81, 1'b1, BIT_CLK);
      wait_done(8, "sb16_81");
      for (n = 0; n < 2000 && done2_count < 1; n++) @(negedge clk);
      #1;
      checks++;
      if (done2_count !== 1) $display("FAIL sb32_done: count=%0d required 1", done2_count);
      else passed++;
      checks++;
      if (dout2 !== 8'h81 || frame_err2 !== 1'b0)
         $display("FAIL sb32_frame: dout=%h frame_err=%b required 81 0", dout2, frame_err2);
      else passed++;
      checks++;
      if (done_cyc2 - done_cyc1 !== 16 * TICK_DIV)
         $display("FAIL sb32_delay: delta=%0d clk required %0d", done_cyc2 - done_cyc1, 16 * TICK_DIV);
      else passed++;
      $display("sb32 frame: dout=%h done %0d clk after sb16", dout2, done_cyc2 - done_cyc1);
      idle(100);
      sel2 = 1'b0;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_glitch;
      test_frame_error;
      test_reset_mid_frame;
      test_back_to_back;
      test_sb32;
      checks++;
      if (exp_q.size() != 0) $display("FAIL leftover: %0d expected frames never received", exp_q.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
